// File: rtl/mlp_acc_top_if.sv
// Load/result bus of the MLP accelerator.
// The master drives load beats; the slave returns the result stream.
interface mlp_acc_top_if;
    logic        load_en_i;
    logic [31:0] load_payload_i;
    logic        load_type_i;
    logic [3:0]  input_load_number;
    logic [2:0]  layer_number;
    logic [2:0]  weight_number;
    logic        result_valid_o;
    logic [31:0] result_payload_o;

    modport master (
        output load_en_i,
        output load_payload_i,
        output load_type_i,
        output input_load_number,
        output layer_number,
        output weight_number,
        input  result_valid_o,
        input  result_payload_o
    );

    modport slave (
        input  load_en_i,
        input  load_payload_i,
        input  load_type_i,
        input  input_load_number,
        input  layer_number,
        input  weight_number,
        output result_valid_o,
        output result_payload_o
    );
endinterface

// File: rtl/mlp_acc_top.sv
// 8-layer 16x16 int16 MLP with single-cycle 32-multiplier MAC beats.
// Define MLP_ACC_RELU_EN to apply ReLU on hidden-layer commits.
module mlp_acc_top (
    input logic         clk,
    input logic         rst_n,
    mlp_acc_top_if.slave bus
);

`ifdef MLP_ACC_RELU_EN
    localparam logic RELU_EN = 1'b1;
`else
    localparam logic RELU_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMMIT,
        S_STREAM
    } state_e;

    state_e state_q, state_d;

    logic signed [15:0] x_q [16];
    logic signed [15:0] x_d [16];
    logic signed [15:0] a_q [16][16];
    logic signed [15:0] a_d [16][16];
    logic signed [35:0] y_q [16][16];
    logic signed [35:0] y_d [16][16];

    logic [2:0] b_q, b_d;
    logic [2:0] cl_q, cl_d;
    logic [6:0] k_q, k_d;
    logic       vld_q, vld_d;

    logic              accept;
    logic signed [15:0] p0, p1;
    logic [3:0]        n;
    logic [3:0]        c0, c1;
    logic              relu;

    function automatic logic signed [31:0] mul(
        input logic signed [15:0] a,
        input logic signed [15:0] b
    );
        return a * b;
    endfunction

    function automatic logic signed [35:0] sx(
        input logic signed [31:0] v
    );
        return {{4{v[31]}}, v};
    endfunction

    function automatic logic signed [15:0] act(
        input logic signed [35:0] v,
        input logic               r
    );
        logic signed [35:0] t;
        t = v;
        if (r && t[35]) t = '0;
        if (t > 36'sd32767) return 16'sh7FFF;
        if (t < -36'sd32768) return 16'sh8000;
        return t[15:0];
    endfunction

    assign accept = bus.load_en_i && (state_q == S_LOAD);
    assign p0     = bus.load_payload_i[15:0];
    assign p1     = bus.load_payload_i[31:16];
    assign n      = bus.input_load_number;
    assign c0     = {bus.weight_number, 1'b0};
    assign c1     = {bus.weight_number, 1'b1};
    assign relu   = RELU_EN && (cl_q != 3'd7);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        y_d     = y_q;
        b_d     = b_q;
        cl_d    = cl_q;
        k_d     = k_q;
        vld_d   = vld_q;
        unique case (state_q)
            S_LOAD: begin
                if (accept && bus.load_type_i) begin
                    x_d[{b_q, 1'b0}] = p0;
                    x_d[{b_q, 1'b1}] = p1;
                    b_d = b_q + 3'd1;
                end else if (accept) begin
                    b_d = '0;
                    // Layer 0 walks W0 by rows, later layers by columns
                    if (bus.layer_number == 3'd0) begin
                        for (int r = 0; r < 16; r++) begin
                            y_d[r][c0] = y_q[r][c0] + sx(mul(x_q[r], p0));
                            y_d[r][c1] = y_q[r][c1] + sx(mul(x_q[r], p1));
                        end
                    end else begin
                        for (int r = 0; r < 16; r++) begin
                            y_d[r][n] = y_q[r][n]
                                      + sx(mul(a_q[r][c0], p0))
                                      + sx(mul(a_q[r][c1], p1));
                        end
                    end
                    if (n == 4'd15 && bus.weight_number == 3'd7) begin
                        state_d = S_COMMIT;
                        cl_d    = bus.layer_number;
                    end
                end
            end
            S_COMMIT: begin
                for (int r = 0; r < 16; r++) begin
                    for (int c = 0; c < 16; c++) begin
                        a_d[r][c] = act(y_q[r][c], relu);
                        y_d[r][c] = '0;
                    end
                end
                if (cl_q == 3'd7) begin
                    state_d = S_STREAM;
                    k_d     = '0;
                    vld_d   = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_STREAM: begin
                k_d = k_q + 7'd1;
                if (k_q == 7'd127) begin
                    state_d = S_LOAD;
                    vld_d   = 1'b0;
                    b_d     = '0;
                    for (int r = 0; r < 16; r++) begin
                        x_d[r] = '0;
                        for (int c = 0; c < 16; c++) begin
                            a_d[r][c] = '0;
                            y_d[r][c] = '0;
                        end
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            b_q     <= '0;
            cl_q    <= '0;
            k_q     <= '0;
            vld_q   <= 1'b0;
            for (int r = 0; r < 16; r++) begin
                x_q[r] <= '0;
                for (int c = 0; c < 16; c++) begin
                    a_q[r][c] <= '0;
                    y_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            cl_q    <= cl_d;
            k_q     <= k_d;
            vld_q   <= vld_d;
            x_q     <= x_d;
            a_q     <= a_d;
            y_q     <= y_d;
        end
    end

    logic [3:0] o_row, o_c0, o_c1;

    assign o_row = k_q[6:3];
    assign o_c0  = {k_q[2:0], 1'b0};
    assign o_c1  = {k_q[2:0], 1'b1};

    assign bus.result_valid_o   = vld_q;
    assign bus.result_payload_o = vld_q
        ? {a_q[o_row][o_c1], a_q[o_row][o_c0]}
        : 32'h0;

endmodule

// File: tb/tb_mlp_acc_top.sv
// Randomised bench for mlp_acc_top against a matrix-level MLP model.
// Stimulus is driven and outputs sampled on the falling edge.
module tb_mlp_acc_top;

`ifdef MLP_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mlp_acc_top_if bus ();

    mlp_acc_top dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    int xm [16][16];
    int wm [8][16][16];
    logic [31:0] exp_s [128];
    logic [31:0] got_s [128];

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rnd16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    function automatic int act(longint v, bit relu);
        if (relu && v < 0) v = 0;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic logic [31:0] pk(int hi, int lo);
        return {hi[15:0], lo[15:0]};
    endfunction

    // kind: 0 identity, 1 W0=-I, 2 saturating, 3 small rnd, 4 full rnd
    task automatic fill(int kind);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int id;
                id = (r == c) ? 1 : 0;
                xm[r][c] = id;
                for (int l = 0; l < 8; l++) wm[l][r][c] = id;
                case (kind)
                    1: wm[0][r][c] = -id;
                    2: begin
                        xm[r][c]    = 32767;
                        wm[0][r][c] = 32767;
                    end
                    3: begin
                        xm[r][c] = $urandom_range(0, 31) - 16;
                        for (int l = 0; l < 8; l++)
                            wm[l][r][c] = $urandom_range(0, 7) - 4;
                    end
                    4: begin
                        xm[r][c] = rnd16();
                        for (int l = 0; l < 8; l++)
                            wm[l][r][c] = rnd16();
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic model();
        int a [16][16];
        longint y [16][16];
        a = xm;
        for (int l = 0; l < 8; l++) begin
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 16; c++) begin
                    y[r][c] = 0;
                    for (int k = 0; k < 16; k++)
                        y[r][c] += longint'(a[r][k]) * longint'(wm[l][k][c]);
                end
            end
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    a[r][c] = act(y[r][c], RELU && l < 7);
        end
        for (int k = 0; k < 128; k++)
            exp_s[k] = pk(a[k/8][2*(k%8)+1], a[k/8][2*(k%8)]);
    endtask

    task automatic beat(bit t, int n, int l, int w, logic [31:0] p);
        bus.load_en_i         = 1'b1;
        bus.load_type_i       = t;
        bus.input_load_number = 4'(n);
        bus.layer_number      = 3'(l);
        bus.weight_number     = 3'(w);
        bus.load_payload_i    = p;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.load_en_i = 1'b0;
        @(negedge clk);
    endtask

    // stop_at >= 0 pulses reset after that many beats and abandons the load
    task automatic load_all(int stop_at, output bit aborted);
        int cnt;
        cnt = 0;
        aborted = 1'b0;
        for (int n = 0; n < 16; n++) begin
            for (int j = 0; j < 16; j++) begin
                if (cnt == stop_at) begin
                    bus.load_en_i = 1'b0;
                    rst_n = 1'b0;
                    @(negedge clk);
                    check("load_rst_valid", 32'(bus.result_valid_o), 0);
                    rst_n = 1'b1;
                    aborted = 1'b1;
                    return;
                end
                cnt++;
                if (j < 8)
                    beat(1, n, 0, 0, pk(xm[2*j+1][n], xm[2*j][n]));
                else
                    beat(0, n, 0, j - 8,
                         pk(wm[0][n][2*(j-8)+1], wm[0][n][2*(j-8)]));
            end
            check("load_payload_zero", bus.result_payload_o, 0);
        end
        idle();
        for (int l = 1; l < 8; l++) begin
            for (int n = 0; n < 16; n++)
                for (int w = 0; w < 8; w++)
                    beat(0, n, l, w, pk(wm[l][2*w+1][n], wm[l][2*w][n]));
            if (l < 7) idle();
        end
        bus.load_en_i = 1'b0;
        check("commit_gap_valid", 32'(bus.result_valid_o), 0);
        check("commit_gap_payload", bus.result_payload_o, 0);
    endtask

    task automatic stream(string tag, bit noise, int abort_at);
        @(negedge clk);
        for (int k = 0; k < 128; k++) begin
            got_s[k] = bus.result_payload_o;
            check({tag, "_valid"}, 32'(bus.result_valid_o), 1);
            check({tag, "_beat"}, got_s[k], exp_s[k]);
            if (k == abort_at) begin
                bus.load_en_i = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                check("abort_valid", 32'(bus.result_valid_o), 0);
                check("abort_payload", bus.result_payload_o, 0);
                rst_n = 1'b1;
                idle();
                check("abort_idle_valid", 32'(bus.result_valid_o), 0);
                return;
            end
            if (noise) begin
                bus.load_en_i         = 1'($urandom);
                bus.load_type_i       = 1'($urandom);
                bus.input_load_number = 4'($urandom);
                bus.layer_number      = 3'($urandom);
                bus.weight_number     = 3'($urandom);
                bus.load_payload_i    = $urandom;
            end
            @(negedge clk);
        end
        bus.load_en_i = 1'b0;
        check({tag, "_end_valid"}, 32'(bus.result_valid_o), 0);
        check({tag, "_end_payload"}, bus.result_payload_o, 0);
    endtask

    task automatic run(string tag, int kind, bit noise, int abort_at);
        bit ab;
        fill(kind);
        model();
        load_all(-1, ab);
        stream(tag, noise, abort_at);
    endtask

    initial begin
        bit ab;
        bus.load_en_i         = 1'b0;
        bus.load_type_i       = 1'b0;
        bus.input_load_number = '0;
        bus.layer_number      = '0;
        bus.weight_number     = '0;
        bus.load_payload_i    = '0;

        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_valid", 32'(bus.result_valid_o), 0);
            check("rst_payload", bus.result_payload_o, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run("ident", 0, 0, -1);
        check("ident_beat0", got_s[0], 32'h0000_0001);
        check("ident_beat8", got_s[8], 32'h0001_0000);
        check("ident_beat9", got_s[9], 32'h0000_0000);

        run("neg", 1, 0, -1);
        check("neg_beat0", got_s[0], RELU ? 32'h0 : 32'h0000_FFFF);

        run("sat", 2, 0, -1);
        check("sat_beat0", got_s[0], 32'h7FFF_7FFF);
        check("sat_beat127", got_s[127], 32'h7FFF_7FFF);

        run("small", 3, 0, -1);
        run("full", 4, 0, -1);
        run("noise", 3, 1, -1);

        run("abort", 0, 0, 40);
        run("fresh", 0, 0, -1);
        check("fresh_beat0", got_s[0], 32'h0000_0001);

        fill(3);
        load_all(35, ab);
        check("partial_aborted", 32'(ab), 1);
        run("after_rst", 3, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
